// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard control bundle: ID/EX hazard inputs and the pipeline
// register controls plus stall statistics returned by the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  branch_taken;
    logic                  muldiv_start;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  idex_hold;
    logic                  muldiv_busy;
    logic                  muldiv_done;
    logic [31:0]           stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, muldiv_start,
        input  pc_write, ifid_write, ifid_flush, idex_flush, idex_hold,
               muldiv_busy, muldiv_done, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, muldiv_start,
        output pc_write, ifid_write, ifid_flush, idex_flush, idex_hold,
               muldiv_busy, muldiv_done, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes, mul/div EX occupancy and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int          MULDIV_CYCLES = 32,
    parameter int          REG_ADDR_W    = 5,
    parameter logic [31:0] STALL_RST     = 32'h0  // stall counter reset value
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, BUSY} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [31:0] stall_q;

    logic pc_write, ifid_write, ifid_flush, idex_flush, idex_hold;
    logic muldiv_busy, muldiv_done;
    logic load_use;

    assign load_use = hz.ex_mem_read && (hz.ex_rt != '0) &&
                      ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
                       (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            cnt     <= '0;
            stall_q <= STALL_RST;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pc_write && (stall_q != 32'hFFFF_FFFF))
                stall_q <= stall_q + 32'd1;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        idex_hold   = 1'b0;
        muldiv_busy = 1'b0;
        muldiv_done = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (hz.branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                    // mul/div entry is independent of this cycle's hazard outputs
                    if (hz.muldiv_start) begin
                        state_nxt = BUSY;
                        cnt_nxt   = 16'(MULDIV_CYCLES - 1);
                    end
                end
                BUSY: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_hold   = 1'b1;
                    muldiv_busy = 1'b1;
                    if (cnt != 16'd0) begin
                        cnt_nxt = cnt - 16'd1;
                    end else begin
                        muldiv_done = 1'b1;
                        state_nxt   = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.ifid_write   = ifid_write;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_flush   = idex_flush;
    assign hz.idex_hold    = idex_hold;
    assign hz.muldiv_busy  = muldiv_busy;
    assign hz.muldiv_done  = muldiv_done;
    assign hz.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal checks, then
// random traffic compared each cycle against a remaining-cycles behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int          MC    = 4;
    localparam int          AW    = 5;
    localparam logic [31:0] SINIT = 32'hFFFF_FFFE;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW)) h0 ();
    pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW)) h1 ();

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(MC), .REG_ADDR_W(AW)) dut0 (
        .clk(clk), .rst(rst), .hz(h0.slave));
    pipeline_hazard_ctrl #(.MULDIV_CYCLES(MC), .REG_ADDR_W(AW), .STALL_RST(SINIT)) dut1 (
        .clk(clk), .rst(rst), .hz(h1.slave));

    // second instance sees identical stimulus; only its stall counter start differs
    assign h1.id_rs        = h0.id_rs;
    assign h1.id_rt        = h0.id_rt;
    assign h1.id_uses_rs   = h0.id_uses_rs;
    assign h1.id_uses_rt   = h0.id_uses_rt;
    assign h1.ex_mem_read  = h0.ex_mem_read;
    assign h1.ex_rt        = h0.ex_rt;
    assign h1.branch_taken = h0.branch_taken;
    assign h1.muldiv_start = h0.muldiv_start;

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: busy_left = mul/div cycles still to spend in EX
    int          busy_left = 0;
    logic [31:0] m_stall0 = 32'h0;
    logic [31:0] m_stall1 = SINIT;
    logic e_pc, e_ifw, e_iff, e_idf, e_hold, e_busy, e_done;
    logic model_on = 1'b1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always @(negedge clk) begin
        logic lu;
        lu = h0.ex_mem_read && (h0.ex_rt != 0) &&
             ((h0.id_uses_rs && h0.id_rs == h0.ex_rt) || (h0.id_uses_rt && h0.id_rt == h0.ex_rt));
        {e_pc, e_ifw, e_iff, e_idf, e_hold, e_busy, e_done} = 7'b1100000;
        if (!rst) begin
            busy_left = 0;
            m_stall0  = 32'h0;
            m_stall1  = SINIT;
        end else if (busy_left > 0) begin
            {e_pc, e_ifw, e_hold, e_busy} = 4'b0011;
            e_done = (busy_left == 1);
        end else if (h0.branch_taken) begin
            {e_iff, e_idf} = 2'b11;
        end else if (lu) begin
            {e_pc, e_ifw, e_idf} = 3'b001;
        end
        if (model_on) begin
            chk1("pc_write", h0.pc_write, e_pc);
            chk1("ifid_write", h0.ifid_write, e_ifw);
            chk1("ifid_flush", h0.ifid_flush, e_iff);
            chk1("idex_flush", h0.idex_flush, e_idf);
            chk1("idex_hold", h0.idex_hold, e_hold);
            chk1("muldiv_busy", h0.muldiv_busy, e_busy);
            chk1("muldiv_done", h0.muldiv_done, e_done);
            chk32("stall_cycles", h0.stall_cycles, m_stall0);
            chk1("pc_write_b", h1.pc_write, e_pc);
            chk1("muldiv_done_b", h1.muldiv_done, e_done);
            chk32("stall_cycles_sat", h1.stall_cycles, m_stall1);
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            busy_left = 0;
            m_stall0  = 32'h0;
            m_stall1  = SINIT;
        end else begin
            if (!e_pc) begin
                m_stall0 = sat_inc(m_stall0);
                m_stall1 = sat_inc(m_stall1);
            end
            if (busy_left > 0)              busy_left = busy_left - 1;
            else if (h0.muldiv_start)       busy_left = MC;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        h0.id_rs = '0; h0.id_rt = '0; h0.id_uses_rs = 1'b0; h0.id_uses_rt = 1'b0;
        h0.ex_mem_read = 1'b0; h0.ex_rt = '0; h0.branch_taken = 1'b0; h0.muldiv_start = 1'b0;
    endtask

    task automatic set_lu(input logic [AW-1:0] r);
        h0.ex_mem_read = 1'b1; h0.ex_rt = r; h0.id_rs = 5'd5; h0.id_uses_rs = 1'b1;
    endtask

    initial begin
        idle();
        h0.branch_taken = 1'b1;
        h0.muldiv_start = 1'b1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk1("rst_pc_write", h0.pc_write, 1'b1);
            chk1("rst_idex_flush", h0.idex_flush, 1'b0);
            chk32("rst_stall", h0.stall_cycles, 32'h0);
        end
        cyc(); rst = 1'b1; idle();
        @(negedge clk); chk1("run_after_rst", h0.muldiv_busy, 1'b0);

        // load-use bubble
        cyc(); set_lu(5'd5);
        @(negedge clk); chk1("lu_pc_write", h0.pc_write, 1'b0); chk1("lu_idex_flush", h0.idex_flush, 1'b1);
        cyc(); idle();
        @(negedge clk); chk32("lu_stall1", h0.stall_cycles, 32'd1); chk1("lu_released", h0.pc_write, 1'b1);
        chk32("sat_reach", h1.stall_cycles, 32'hFFFF_FFFF);
        // ex_rt = 0 never stalls
        cyc(); set_lu(5'd0);
        @(negedge clk); chk1("lu_r0_pc_write", h0.pc_write, 1'b1);
        // branch over load-use
        cyc(); set_lu(5'd5); h0.branch_taken = 1'b1;
        @(negedge clk); chk1("br_ifid_flush", h0.ifid_flush, 1'b1); chk1("br_pc_write", h0.pc_write, 1'b1);
        cyc(); idle();
        @(negedge clk); chk32("br_stall_same", h0.stall_cycles, 32'd1);

        // mul/div occupancy
        cyc(); h0.muldiv_start = 1'b1;
        @(negedge clk); chk1("md_start_cycle", h0.muldiv_busy, 1'b0);
        cyc(); idle();
        @(negedge clk); chk1("md_b1_busy", h0.muldiv_busy, 1'b1); chk1("md_b1_done", h0.muldiv_done, 1'b0);
        cyc(); h0.branch_taken = 1'b1;
        @(negedge clk); chk1("md_b2_noflush", h0.ifid_flush, 1'b0); chk1("md_b2_hold", h0.idex_hold, 1'b1);
        cyc(); idle();
        @(negedge clk); chk1("md_b3_done", h0.muldiv_done, 1'b0);
        cyc();
        @(negedge clk); chk1("md_b4_done", h0.muldiv_done, 1'b1);
        cyc();
        @(negedge clk); chk1("md_after_busy", h0.muldiv_busy, 1'b0); chk32("md_stall5", h0.stall_cycles, 32'd5);
        chk32("sat_hold", h1.stall_cycles, 32'hFFFF_FFFF);

        // reset on busy cycle 2
        cyc(); h0.muldiv_start = 1'b1;
        cyc(); idle();
        cyc(); rst = 1'b0;
        @(negedge clk); chk1("mr_busy", h0.muldiv_busy, 1'b0); chk1("mr_done", h0.muldiv_done, 1'b0);
        chk32("mr_stall", h0.stall_cycles, 32'h0);
        cyc(); rst = 1'b1;
        @(negedge clk); chk1("mr_run", h0.pc_write, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst             = ($urandom_range(0, 149) != 0);
            h0.id_rs        = AW'($urandom_range(0, 7));
            h0.id_rt        = AW'($urandom_range(0, 7));
            h0.id_uses_rs   = 1'($urandom_range(0, 1));
            h0.id_uses_rt   = 1'($urandom_range(0, 1));
            h0.ex_mem_read  = 1'($urandom_range(0, 1));
            h0.ex_rt        = AW'($urandom_range(0, 7));
            h0.branch_taken = ($urandom_range(0, 99) < 15);
            h0.muldiv_start = ($urandom_range(0, 99) < 10);
        end
        cyc(); idle(); rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        model_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage pipeline. It drives the PC write enable and the write, flush and hold controls of the IF/ID and ID/EX pipeline registers. It resolves three hazards: load-use stalls, taken-branch flushes, and multi-cycle mul/div occupancy of EX. It also keeps a saturating stall-cycle performance counter.

Parameters:
MULDIV_CYCLES, 32, EX-stage busy cycles for a mul/div operation; legal range 1..65535
REG_ADDR_W, 5, register-specifier width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset asserted)
id_rs  in  REG_ADDR_W  rs field of the instruction at the IF/ID output
id_rt  in  REG_ADDR_W  rt field of the instruction at the IF/ID output
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  EX instruction is a load
ex_rt  in  REG_ADDR_W  destination register of the EX load
branch_taken  in  1  branch/jump resolved taken in EX this cycle
muldiv_start  in  1  EX instruction is a mul/div, single-cycle pulse
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_flush  out  1  ID/EX clear to bubble
idex_hold  out  1  ID/EX keeps its current contents
muldiv_busy  out  1  mul/div is occupying EX
muldiv_done  out  1  one-cycle pulse on the final busy cycle
stall_cycles  out  32  count of cycles with pc_write=0, saturating

Behaviour:
- State: RUN or BUSY. Down-counter cnt is 16 bits.
- Reset (rst=0, asynchronous): state=RUN, cnt=0, stall_cycles=0.
  - While rst=0, outputs are forced: pc_write=1, ifid_write=1; ifid_flush, idex_flush, idex_hold, muldiv_busy, muldiv_done all 0.
  - On reset release the next edge is a normal RUN cycle.
  - Reset mid-BUSY aborts the mul/div immediately. muldiv_done does not pulse.
- Control outputs are combinational from state, cnt and inputs (Mealy). Zero-cycle latency. State, cnt and stall_cycles update on the rising edge of clk.
- load_use = ex_mem_read & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- RUN, priority order:
  1. branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. load_use is ignored because the ID instruction is squashed.
  2. Else load_use=1: pc_write=0, ifid_write=0, idex_flush=1. This inserts exactly one bubble; the next cycle the load is in MEM and load_use is naturally 0.
  3. Else: pc_write=1, ifid_write=1, all flush/hold outputs 0.
  - muldiv_start=1 in RUN is evaluated independently of the above:
    - It does not change the current cycle's outputs.
    - Next state=BUSY and cnt<=MULDIV_CYCLES-1.
    - If it coincides with branch_taken, the branch flush applies this cycle and BUSY is still entered.
- BUSY:
  - Outputs: pc_write=0, ifid_write=0, idex_hold=1, muldiv_busy=1, ifid_flush=0, idex_flush=0.
  - branch_taken, muldiv_start and load_use are ignored because EX is frozen.
  - If cnt!=0: cnt<=cnt-1 and stay in BUSY.
  - If cnt==0: muldiv_done=1 this cycle, next state=RUN.
  - BUSY therefore lasts exactly MULDIV_CYCLES cycles. With MULDIV_CYCLES=1 it is a single cycle with muldiv_done=1.
- stall_cycles: increments by 1 on each clock edge where pc_write=0 (load-use and BUSY cycles). It holds at 32'hFFFF_FFFF and does not wrap.

Test Plan:
- Reset: hold rst=0 for 3 cycles with branch_taken=1 and muldiv_start=1 -> pc_write=1, ifid_write=1, all others 0, stall_cycles=0. Release: state RUN.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5, id_uses_rs=1 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1, then normal; stall_cycles=1. Repeat with ex_rt=0 -> no stall.
- Branch over load-use: branch_taken=1 with the load-use condition true -> ifid_flush=1, idex_flush=1, pc_write=1; stall_cycles unchanged.
- Mul/div with MULDIV_CYCLES=4: pulse muldiv_start -> next 4 cycles muldiv_busy=1, idex_hold=1, pc_write=0; muldiv_done=1 only on the 4th; stall_cycles=4. branch_taken=1 during BUSY -> no flush.
- Reset mid-BUSY: rst=0 on busy cycle 2 -> outputs immediately in reset state, no muldiv_done, stall_cycles=0; after release, RUN.
- Saturation: preload or force stall_cycles=32'hFFFF_FFFE, then apply 3 stall cycles -> reads 32'hFFFF_FFFF and holds.
